// File: rtl/param_memory.sv
// Byte-masked one-read/one-write word memory with a registered read port and a
// controller FSM; defining PARAM_MEMORY_CLEAR_EN adds a zero-fill CLEAR sequence after reset.
module param_memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_enable,
    input  logic [ADDR_W-1:0]   read_addr,
    output logic [DATA_W-1:0]   read_data,
    output logic                read_valid,
    input  logic                write_enable,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] write_mask,
    output logic                busy,
    output logic                addr_error,
    output logic [1:0]          fsm_state_o
);

    localparam int              NBYTES  = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    // Handshake: read_enable/write_enable are single-cycle strobes sampled at each
    // rising edge while busy is low; there is no other back-pressure. Responses
    // (read_valid, addr_error) are one-cycle pulses in the following cycle.

`ifdef PARAM_MEMORY_CLEAR_EN
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] LAST_W = DEPTH_W - 1'b1;

    logic [ADDR_W:0] clr_cnt_q;
`else
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        READY = 2'd2
    } state_e;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q;
    logic              busy_q;
    logic              read_valid_q;
    logic              addr_error_q;
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] read_data_d;

    logic              rd_oor;
    logic              wr_oor;
    logic              rd_acc;
    logic              wr_acc;
    logic              err_d;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] rd_old;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NBYTES-1:0] mask
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NBYTES; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign rd_oor = ({1'b0, read_addr} >= DEPTH_W);
    assign wr_oor = ({1'b0, write_addr} >= DEPTH_W);
    assign rd_acc = read_enable && !busy_q;
    assign wr_acc = write_enable && !busy_q && !wr_oor;
    assign err_d  = !busy_q && ((read_enable && rd_oor) || (write_enable && wr_oor));

    // Out-of-range addresses never reach the array; index 0 is a harmless stand-in.
    assign rd_idx = rd_oor ? '0 : read_addr;
    assign wr_idx = wr_oor ? '0 : write_addr;

    always_comb begin
        rd_old      = mem[rd_idx];
        wr_old      = mem[wr_idx];
        wr_word     = merge_bytes(wr_old, write_data, write_mask);
        rd_word     = rd_old;
        read_data_d = read_data_q;
        if (wr_acc && (write_addr == read_addr)) begin
            rd_word = wr_word;
        end
        if (rd_acc) begin
            read_data_d = rd_oor ? '0 : rd_word;
        end
    end

    // Storage array: no reset, only CLEAR (busy) or accepted writes (not busy) touch it.
    always_ff @(posedge clk) begin
`ifdef PARAM_MEMORY_CLEAR_EN
        if (rst && (state_q == CLEAR)) begin
            mem[clr_cnt_q[ADDR_W-1:0]] <= '0;
        end
`endif
        if (rst && wr_acc) begin
            mem[write_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= INIT;
            busy_q       <= 1'b1;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            addr_error_q <= 1'b0;
`ifdef PARAM_MEMORY_CLEAR_EN
            clr_cnt_q    <= '0;
`endif
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= rd_acc;
            addr_error_q <= err_d;
            case (state_q)
                INIT: begin
`ifdef PARAM_MEMORY_CLEAR_EN
                    state_q   <= CLEAR;
                    clr_cnt_q <= '0;
`else
                    state_q   <= READY;
                    busy_q    <= 1'b0;
`endif
                end
`ifdef PARAM_MEMORY_CLEAR_EN
                CLEAR: begin
                    if (clr_cnt_q == LAST_W) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
`endif
                READY: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= INIT;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign read_data   = read_data_q;
    assign read_valid  = read_valid_q;
    assign addr_error  = addr_error_q;
    assign busy        = busy_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_param_memory.sv
// Self-checking bench for param_memory: directed vector table, reset/busy sequences
// and randomized traffic checked against an address-indexed reference memory.
`timescale 1ns/1ps
module tb_param_memory;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;
    localparam int NB     = DATA_W / 8;
`ifdef PARAM_MEMORY_CLEAR_EN
    localparam int EXP_BUSY = DEPTH + 1;
`else
    localparam int EXP_BUSY = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              read_enable;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              write_enable;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [NB-1:0]     write_mask;
    logic              busy;
    logic              addr_error;
    logic [1:0]        fsm_state;

    param_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .read_enable(read_enable), .read_addr(read_addr),
        .read_data(read_data), .read_valid(read_valid),
        .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data), .write_mask(write_mask),
        .busy(busy), .addr_error(addr_error), .fsm_state_o(fsm_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard state
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_hold;
    logic [DATA_W-1:0] ref_mem[int];

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [NB-1:0]     wm;
        logic              re;
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] exp_data;
        logic              exp_valid;
        logic              exp_err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [NB-1:0] m);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++) begin
            if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic void model_write(input logic we, input logic [ADDR_W-1:0] wa,
                                        input logic [DATA_W-1:0] wd, input logic [NB-1:0] wm);
        if (we && int'(wa) < DEPTH) begin
            if (ref_mem.exists(int'(wa))) ref_mem[int'(wa)] = merge(ref_mem[int'(wa)], wd, wm);
            else if (wm == '1) ref_mem[int'(wa)] = wd;
        end
    endfunction

    function automatic void model_clear();
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    endfunction

    // Driver tasks
    task automatic drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic [NB-1:0] wm, input logic re, input logic [ADDR_W-1:0] ra);
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        write_mask   = wm;
        read_enable  = re;
        read_addr    = ra;
    endtask

    task automatic drive_idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Holds reset for two edges with requests pending, checks reset values, releases.
    task automatic do_reset();
        rst = 1'b0;
        drive(1'b1, 10'd5, 16'h0000, 2'b11, 1'b1, 10'd1000);
        step();
        step();
        check("rst_read_data", read_data, 0);
        check("rst_read_valid", read_valid, 0);
        check("rst_addr_error", addr_error, 0);
        check("rst_busy", busy, 1);
        exp_hold = '0;
        drive_idle();
        rst = 1'b1;
    endtask

    // Counts edges until busy falls, issuing requests that must all be ignored.
    task automatic wait_ready(input logic [ADDR_W-1:0] wa, output int cycles);
        cycles = 0;
        while (busy !== 1'b0 && cycles < 3000) begin
            case (cycles % 3)
                0: drive(1'b1, wa, 16'hFFFF, 2'b11, 1'b1, 10'd1000);
                1: drive(1'b1, 10'd1010, 16'h1234, 2'b11, 1'b1, wa);
                default: drive(1'b1, wa, 16'hA5A5, 2'b01, 1'b0, '0);
            endcase
            step();
            cycles++;
            check("busy_ignore_valid", read_valid, 0);
            check("busy_ignore_err", addr_error, 0);
        end
        drive_idle();
    endtask

    // One READY-state cycle checked against the reference model.
    task automatic cycle(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic [NB-1:0] wm, input logic re, input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] w;
        logic              e;
        e = (re && int'(ra) >= DEPTH) || (we && int'(wa) >= DEPTH);
        if (re) begin
            if (int'(ra) >= DEPTH) w = '0;
            else begin
                w = ref_mem[int'(ra)];
                if (we && wa == ra) w = merge(w, wd, wm);
            end
            exp_q.push_back(w);
        end
        model_write(we, wa, wd, wm);
        drive(we, wa, wd, wm, re, ra);
        step();
        check("read_valid", read_valid, re);
        check("addr_error", addr_error, e);
        if (re && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            exp_hold = w;
            check("read_data", read_data, w);
        end else begin
            check("read_hold", read_data, exp_hold);
        end
        drive_idle();
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return ADDR_W'($urandom_range(0, 15));
        else if (r < 8) return ADDR_W'($urandom_range(990, 999));
        return ADDR_W'($urandom_range(1000, 1023));
    endfunction

    initial begin
        int cyc;
        vecs[0]  = '{1'b1, 10'd5,    16'hBEEF, 2'b11, 1'b0, 10'd0,    16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 10'd0,    16'h0000, 2'b00, 1'b1, 10'd5,    16'hBEEF, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 10'd7,    16'h1234, 2'b11, 1'b0, 10'd0,    16'hBEEF, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 10'd7,    16'hABCD, 2'b01, 1'b1, 10'd7,    16'h12CD, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 10'd0,    16'h0000, 2'b00, 1'b1, 10'd7,    16'h12CD, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 10'd1000, 16'hFFFF, 2'b11, 1'b0, 10'd0,    16'h12CD, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 10'd0,    16'h0000, 2'b00, 1'b1, 10'd1000, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 10'd1000, 16'h5555, 2'b11, 1'b1, 10'd1000, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 10'd0,    16'h0000, 2'b00, 1'b0, 10'd0,    16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 10'd9,    16'h5566, 2'b11, 1'b0, 10'd0,    16'h0000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 10'd9,    16'hAA77, 2'b10, 1'b1, 10'd9,    16'hAA66, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 10'd0,    16'h0000, 2'b00, 1'b1, 10'd1023, 16'h0000, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 10'd1001, 16'h0001, 2'b11, 1'b1, 10'd5,    16'hBEEF, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 10'd0,    16'h0000, 2'b00, 1'b0, 10'd0,    16'hBEEF, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 10'd3,    16'hFFFF, 2'b11, 1'b1, 10'd9,    16'hAA66, 1'b1, 1'b0};

        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        do_reset();
        wait_ready(10'd0, cyc);
        check("busy_cycles_after_reset", cyc, EXP_BUSY);
`ifdef PARAM_MEMORY_CLEAR_EN
        model_clear();
        cycle(1'b0, '0, '0, '0, 1'b1, 10'd0);
        cycle(1'b0, '0, '0, '0, 1'b1, 10'd999);
`endif

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].wm, vecs[i].re, vecs[i].ra);
            model_write(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].wm);
            step();
            check($sformatf("vec%0d_valid", i), read_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_err", i), addr_error, vecs[i].exp_err);
            check($sformatf("vec%0d_data", i), read_data, vecs[i].exp_data);
            check($sformatf("vec%0d_busy", i), busy, 0);
            exp_hold = vecs[i].exp_data;
        end
        drive_idle();

`ifdef PARAM_MEMORY_CLEAR_EN
        // Reset after preload: CLEAR must wipe address 3
        do_reset();
        wait_ready(10'd0, cyc);
        check("clear_busy_cycles", cyc, DEPTH + 1);
        model_clear();
        cycle(1'b0, '0, '0, '0, 1'b1, 10'd3);
        cycle(1'b0, '0, '0, '0, 1'b1, 10'd5);
        // Reset mid-CLEAR restarts the full sweep
        cycle(1'b1, 10'd600, 16'h7777, 2'b11, 1'b0, '0);
        do_reset();
        repeat (502) step();
        check("mid_clear_busy", busy, 1);
        do_reset();
        wait_ready(10'd0, cyc);
        check("restart_busy_cycles", cyc, DEPTH + 1);
        model_clear();
        cycle(1'b0, '0, '0, '0, 1'b1, 10'd600);
        cycle(1'b0, '0, '0, '0, 1'b1, 10'd0);
`else
        // Reset with ignored writes to 5: contents must survive
        do_reset();
        wait_ready(10'd5, cyc);
        check("reset_busy_cycles", cyc, 1);
        cycle(1'b0, '0, '0, '0, 1'b1, 10'd5);
        cycle(1'b0, '0, '0, '0, 1'b1, 10'd7);
`endif

        // Randomized traffic on a fully known address set
        for (int a = 0; a < 16; a++)
            cycle(1'b1, ADDR_W'(a), DATA_W'($urandom), 2'b11, 1'b0, '0);
        for (int a = 990; a < 1000; a++)
            cycle(1'b1, ADDR_W'(a), DATA_W'($urandom), 2'b11, 1'b0, '0);
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), pick_addr(), DATA_W'($urandom),
                  NB'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick_addr());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
